gateway_tx_route: RTL and testbench

TX-path routing enforcement for the VIU, the outgoing counterpart of the RX gateway. Checks each outgoing AXI-Stream packet's requested destination (node + vFPGA) against a host-programmed capability table and drops disallowed packets whole. For permitted packets it emits the 14-bit route word that the VLAN tagger encodes into the tag, with fields {src_node, src_vfpga, dst_node, dst_vfpga, 2'b00}. Sits between the vFPGA's network TX stream and the vlan_tagger.

---
 rtl/gateway_tx_route_if.sv | 27 ++
 rtl/gateway_tx_route.sv | 174 +++++++++++++++++
 tb/tb_gateway_tx_route.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gateway_tx_route_if.sv
// gateway_tx_route_if
//
// Purpose: AXI-Stream bundle used for both the input (vFPGA TX) and the
// output (towards the vlan_tagger) side of gateway_tx_route.
//
// Signals:
//   tdata   DATA_BITS      beat payload
//   tkeep   DATA_BITS/8    byte enables
//   tlast   1              last beat of a packet
//   tvalid  1              source has a beat
//   tready  1              sink accepts the beat
//
// Modports:
//   master  drives tdata/tkeep/tlast/tvalid, samples tready
//   slave   samples tdata/tkeep/tlast/tvalid, drives tready
interface gateway_tx_route_if #(
  parameter int DATA_BITS = 512
);
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/gateway_tx_route.sv
// gateway_tx_route
//
// Purpose: TX-path routing enforcement. Each outgoing packet's requested
// destination (s_dst, sampled on the head beat) is checked against a
// host-programmed capability table. Permitted packets are forwarded through a
// single register stage together with a 14-bit route word
// {src_node, src_vfpga, dst_node, dst_vfpga, 2'b00}; disallowed packets are
// swallowed whole and counted.
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   cfg_valid       one-cycle write strobe for cfg_data
//   cfg_data[13:0]  [13:8] allowed dst, [7:2] this node/vfpga, [1:0] slot
//   s_axis          input stream (slave modport)
//   s_dst[5:0]      {dst_node, dst_vfpga} of the packet, head beat only
//   m_axis          output stream (master modport)
//   m_route[13:0]   route word for the packet currently on m_axis
//   pkt_cnt         forwarded packets, saturating
//   drop_cnt        dropped packets, saturating
//
// Parameters:
//   N_DESTS    capability table slots (1..4)
//   DATA_BITS  stream data width
//
// Build option:
//   VIU_TX_LOOPBACK_DROP_EN  when defined, a packet addressed to this node's
//                            own {node, vfpga} is dropped even if the table
//                            would allow it.
module gateway_tx_route #(
  parameter int N_DESTS   = 4,
  parameter int DATA_BITS = 512
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_valid,
  input  logic [13:0]         cfg_data,
  gateway_tx_route_if.slave   s_axis,
  input  logic [5:0]          s_dst,
  gateway_tx_route_if.master  m_axis,
  output logic [13:0]         m_route,
  output logic [31:0]         pkt_cnt,
  output logic [31:0]         drop_cnt
);

  typedef enum logic [1:0] {
    HEAD = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [5:0]         tbl_dst [N_DESTS];
  logic [N_DESTS-1:0] tbl_vld;
  logic [5:0]         identity;

  logic table_hit;
  logic allowed;
  logic out_free;
  logic accept;
  logic load;

  // Destination lookup against the currently programmed table. A write in
  // the same cycle lands on the clock edge, so a head beat always sees the
  // pre-write contents.
  always_comb begin
    table_hit = 1'b0;
    for (int i = 0; i < N_DESTS; i++) begin
      if (tbl_vld[i] && (tbl_dst[i] == s_dst)) begin
        table_hit = 1'b1;
      end
    end
  end

  // Destination 0 is the external network and is always reachable.
`ifdef VIU_TX_LOOPBACK_DROP_EN
  assign allowed = ((s_dst == 6'd0) || table_hit) && (s_dst != identity);
`else
  assign allowed = (s_dst == 6'd0) || table_hit;
`endif

  assign out_free = !m_axis.tvalid || m_axis.tready;

  // A disallowed head beat never needs the output register, so it is taken
  // even while the output is stalled; the same holds for the rest of a
  // dropped packet.
  always_comb begin
    s_axis.tready = 1'b0;
    if (aresetn) begin
      case (state)
        DROP:    s_axis.tready = 1'b1;
        HEAD:    s_axis.tready = !allowed || out_free;
        default: s_axis.tready = out_free;
      endcase
    end
  end

  assign accept = s_axis.tvalid && s_axis.tready;
  assign load   = accept && ((state == FWD) || ((state == HEAD) && allowed));

  // Packet FSM, output register stage, counters and configuration state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= HEAD;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tkeep  <= '0;
      m_axis.tlast  <= 1'b0;
      m_route       <= '0;
      pkt_cnt       <= '0;
      drop_cnt      <= '0;
      tbl_vld       <= '0;
      identity      <= 6'b01_0000;
      for (int i = 0; i < N_DESTS; i++) begin
        tbl_dst[i] <= '0;
      end
    end else begin
      if (m_axis.tvalid && m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end

      if (load) begin
        m_axis.tvalid <= 1'b1;
        m_axis.tdata  <= s_axis.tdata[DATA_BITS-1:0];
        m_axis.tkeep  <= s_axis.tkeep[DATA_BITS/8-1:0];
        m_axis.tlast  <= s_axis.tlast;
      end

      if (accept) begin
        case (state)
          HEAD: begin
            if (allowed) begin
              m_route <= {identity, s_dst, 2'b00};
              if (pkt_cnt != 32'hFFFF_FFFF) begin
                pkt_cnt <= pkt_cnt + 32'd1;
              end
              state <= s_axis.tlast ? HEAD : FWD;
            end else begin
              if (drop_cnt != 32'hFFFF_FFFF) begin
                drop_cnt <= drop_cnt + 32'd1;
              end
              state <= s_axis.tlast ? HEAD : DROP;
            end
          end
          FWD: begin
            if (s_axis.tlast) begin
              state <= HEAD;
            end
          end
          DROP: begin
            if (s_axis.tlast) begin
              state <= HEAD;
            end
          end
          default: state <= HEAD;
        endcase
      end

      // Slot indices that do not exist in this build match no loop
      // iteration and are therefore ignored.
      if (cfg_valid) begin
        if (cfg_data[7:2] != 6'd0) begin
          identity <= cfg_data[7:2];
        end
        for (int i = 0; i < N_DESTS; i++) begin
          if (cfg_data[1:0] == 2'(i)) begin
            tbl_dst[i] <= cfg_data[13:8];
            tbl_vld[i] <= (cfg_data[13:8] != 6'd0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gateway_tx_route.sv
// tb_gateway_tx_route
//
// Purpose: bench for gateway_tx_route. A packet-level reference model (table
// lookup, expected-beat queue, counters) tracks what must leave the block;
// one compare process checks the DUT against it every cycle, and a few
// literal values after directed scenarios pin the model.
`timescale 1ns/1ps
module tb_gateway_tx_route;

  localparam int DATA_BITS = 512;
  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int N_DESTS   = 4;

  logic        aclk      = 1'b0;
  logic        aresetn   = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [13:0] cfg_data  = '0;
  logic [5:0]  s_dst     = '0;
  logic [13:0] m_route;
  logic [31:0] pkt_cnt;
  logic [31:0] drop_cnt;

  gateway_tx_route_if #(.DATA_BITS(DATA_BITS)) s_if ();
  gateway_tx_route_if #(.DATA_BITS(DATA_BITS)) m_if ();

  gateway_tx_route #(
    .N_DESTS   (N_DESTS),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .s_axis    (s_if),
    .s_dst     (s_dst),
    .m_axis    (m_if),
    .m_route   (m_route),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_BITS-1:0] data;
    logic [KEEP_BITS-1:0] keep;
    logic                 last;
  } beat_t;

  // Reference model state
  beat_t       exp_q[$];
  logic [5:0]  mdl_tbl [N_DESTS];
  logic [5:0]  mdl_id     = 6'h10;
  logic [13:0] mdl_route  = '0;
  logic [31:0] mdl_pkt    = '0;
  logic [31:0] mdl_drop   = '0;
  bit          mdl_in_pkt = 1'b0;
  bit          mdl_pkt_ok = 1'b0;
  bit          acc_flag   = 1'b0;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  task automatic checkOutput(input string name, input logic [DATA_BITS-1:0] act,
                             input logic [DATA_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic bit mdl_allowed(input logic [5:0] dst);
    bit ok;
    ok = (dst == 6'd0);
    for (int i = 0; i < N_DESTS; i++) begin
      if (mdl_tbl[i] != 6'd0 && mdl_tbl[i] == dst) ok = 1'b1;
    end
`ifdef VIU_TX_LOOPBACK_DROP_EN
    if (dst == mdl_id) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [DATA_BITS-1:0] randData();
    logic [DATA_BITS-1:0] d;
    for (int i = 0; i < DATA_BITS / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Compare process: check DUT against the model, then advance the model by
  // the beat/cfg activity that the coming rising edge will perform.
  initial begin : compare_proc
    bit    acc;
    bit    ok;
    bit    exp_rdy;
    beat_t b;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        checkOutput("rst_s_tready", s_if.tready, 0);
        checkOutput("rst_m_tvalid", m_if.tvalid, 0);
        checkOutput("rst_m_tdata", m_if.tdata, 0);
        checkOutput("rst_m_tkeep", m_if.tkeep, 0);
        checkOutput("rst_m_tlast", m_if.tlast, 0);
        checkOutput("rst_m_route", m_route, 0);
        checkOutput("rst_pkt_cnt", pkt_cnt, 0);
        checkOutput("rst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        for (int i = 0; i < N_DESTS; i++) mdl_tbl[i] = 6'd0;
        mdl_id     = 6'h10;
        mdl_route  = '0;
        mdl_pkt    = '0;
        mdl_drop   = '0;
        mdl_in_pkt = 1'b0;
        mdl_pkt_ok = 1'b0;
        acc_flag   = 1'b0;
      end else begin
        if (mdl_in_pkt)
          exp_rdy = mdl_pkt_ok ? (exp_q.size() == 0 || m_if.tready) : 1'b1;
        else
          exp_rdy = !mdl_allowed(s_dst) || exp_q.size() == 0 || m_if.tready;

        checkOutput("s_tready", s_if.tready, exp_rdy);
        checkOutput("m_tvalid", m_if.tvalid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          checkOutput("m_tdata", m_if.tdata, exp_q[0].data);
          checkOutput("m_tkeep", m_if.tkeep, exp_q[0].keep);
          checkOutput("m_tlast", m_if.tlast, exp_q[0].last);
        end
        checkOutput("m_route", m_route, mdl_route);
        checkOutput("pkt_cnt", pkt_cnt, mdl_pkt);
        checkOutput("drop_cnt", drop_cnt, mdl_drop);

        acc = s_if.tvalid && exp_rdy;
        if (exp_q.size() != 0 && m_if.tready) void'(exp_q.pop_front());
        if (acc) begin
          b.data = s_if.tdata;
          b.keep = s_if.tkeep;
          b.last = s_if.tlast;
          if (!mdl_in_pkt) begin
            ok = mdl_allowed(s_dst);
            mdl_pkt_ok = ok;
            if (ok) begin
              mdl_route = {mdl_id, s_dst, 2'b00};
              if (mdl_pkt != 32'hFFFF_FFFF) mdl_pkt = mdl_pkt + 1;
            end else begin
              if (mdl_drop != 32'hFFFF_FFFF) mdl_drop = mdl_drop + 1;
            end
          end
          if (mdl_pkt_ok) exp_q.push_back(b);
          mdl_in_pkt = !s_if.tlast;
        end
        if (cfg_valid) begin
          if (cfg_data[7:2] != 6'd0) mdl_id = cfg_data[7:2];
          if (int'(cfg_data[1:0]) < N_DESTS) mdl_tbl[cfg_data[1:0]] = cfg_data[13:8];
        end
        acc_flag = acc;
      end
    end
  end

  // Output back-pressure: 0 always ready, 1 random, 2 repeating 1-0-0-1.
  initial begin : ready_proc
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        1:       m_if.tready = ($urandom_range(0, 99) < 70);
        2: begin
          m_if.tready = (rdy_phase == 0) || (rdy_phase == 3);
          rdy_phase   = (rdy_phase + 1) % 4;
        end
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  task automatic cfgWrite(input logic [13:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(posedge aclk);
    #1;
    cfg_valid = 1'b0;
  endtask

  // Sends one packet; abort_after > 0 asserts reset once that many beats
  // have been accepted.
  task automatic applyStimulus(input logic [5:0] dst, input int nbeats,
                               input bit gaps, input int abort_after);
    int n;
    for (int b = 0; b < nbeats; b++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = randData();
      s_if.tkeep  = {$urandom, $urandom};
      s_if.tlast  = (b == nbeats - 1);
      s_dst       = (b == 0) ? dst : 6'($urandom);
      n = 0;
      do begin
        @(posedge aclk);
        n++;
      end while (!acc_flag && n < 200);
      #1;
      if (!acc_flag && n >= 200) begin
        failTimeout("beat_accept");
        s_if.tvalid = 1'b0;
        s_dst       = '0;
        return;
      end
      if (abort_after > 0 && b + 1 == abort_after) begin
        s_if.tvalid = 1'b0;
        s_dst       = '0;
        aresetn     = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end
        aresetn = 1'b1;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) begin @(posedge aclk); #1; end
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_dst       = '0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_q.size() != 0 || mdl_in_pkt) && n < 200) begin
      @(posedge aclk);
      n++;
    end
    if (n >= 200) failTimeout("drain");
    repeat (2) begin @(posedge aclk); #1; end
  endtask

  initial begin : main_proc
    logic [5:0]  rdst;
    logic [13:0] rcfg;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    $display("[TB] external destination packet");
    applyStimulus(6'h00, 3, 1'b0, 0);
    waitIdle();
    checkOutput("ext_route", m_route, 14'h1000);
    checkOutput("ext_pkt_cnt", pkt_cnt, 32'd1);

    $display("[TB] table-permitted packet");
    cfgWrite(14'h2148);
    applyStimulus(6'h21, 2, 1'b0, 0);
    waitIdle();
    checkOutput("tbl_route", m_route, 14'h1284);
    checkOutput("tbl_pkt_cnt", pkt_cnt, 32'd2);

    $display("[TB] disallowed packet then allowed packet");
    applyStimulus(6'h13, 4, 1'b0, 0);
    waitIdle();
    checkOutput("drop_cnt_1", drop_cnt, 32'd1);
    checkOutput("drop_route_held", m_route, 14'h1284);
    applyStimulus(6'h00, 2, 1'b0, 0);
    waitIdle();
    checkOutput("after_drop_route", m_route, 14'h1200);
    checkOutput("after_drop_pkt_cnt", pkt_cnt, 32'd3);

    $display("[TB] stalled output pattern");
    rdy_phase = 0;
    rdy_mode  = 2;
    applyStimulus(6'h21, 5, 1'b0, 0);
    waitIdle();
    rdy_mode = 0;
    waitIdle();
    checkOutput("stall_pkt_cnt", pkt_cnt, 32'd4);

    $display("[TB] slot cleared mid-packet");
    fork
      applyStimulus(6'h21, 6, 1'b0, 0);
      begin
        repeat (2) begin @(posedge aclk); #1; end
        cfgWrite(14'h0000);
      end
    join
    waitIdle();
    checkOutput("midclr_pkt_cnt", pkt_cnt, 32'd5);
    applyStimulus(6'h21, 2, 1'b0, 0);
    waitIdle();
    checkOutput("midclr_drop_cnt", drop_cnt, 32'd2);

    $display("[TB] packet to own identity");
    cfgWrite(14'h1249);
    applyStimulus(6'h12, 3, 1'b0, 0);
    waitIdle();
`ifdef VIU_TX_LOOPBACK_DROP_EN
    checkOutput("loop_drop_cnt", drop_cnt, 32'd3);
    checkOutput("loop_pkt_cnt", pkt_cnt, 32'd5);
`else
    checkOutput("loop_pkt_cnt", pkt_cnt, 32'd6);
    checkOutput("loop_route", m_route, 14'h1248);
`endif

    $display("[TB] randomized traffic");
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 4))
        0:       rdst = 6'h00;
        1:       rdst = 6'h21;
        2:       rdst = 6'h12;
        3:       rdst = 6'h13;
        default: rdst = 6'($urandom);
      endcase
      rcfg = {($urandom_range(0, 1) != 0) ? 6'h21 : 6'($urandom),
              ($urandom_range(0, 2) == 0) ? 6'h00 : 6'($urandom),
              2'($urandom)};
      fork
        applyStimulus(rdst, $urandom_range(1, 5), 1'b1, 0);
        begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 3)) begin @(posedge aclk); #1; end
            cfgWrite(rcfg);
          end
        end
      join
    end
    rdy_mode = 0;
    waitIdle();

    $display("[TB] reset in the middle of a packet");
    applyStimulus(6'h00, 5, 1'b0, 2);
    applyStimulus(6'h00, 2, 1'b0, 0);
    waitIdle();
    checkOutput("post_rst_pkt_cnt", pkt_cnt, 32'd1);
    checkOutput("post_rst_drop_cnt", drop_cnt, 32'd0);
    checkOutput("post_rst_route", m_route, 14'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
